// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed program image and writes it word-by-word into instruction memory.
// Optional `BOOT_CHECKSUM_EN adds a trailing 8-bit sum over the data bytes that must match before the cpu is released.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 12,
  parameter int TIMEOUT_CLKS = 10000000
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  input  logic                  uart_txd_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_run,
  output logic                  boot_err,
  output logic                  frame_err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [16:0]      MAX_LEN   = 17'(2 ** ADDR_WIDTH);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef BOOT_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  rx_state_t        r_rx_state;
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_rx_valid;
  logic [7:0]       r_rx_byte;

  state_t           r_state;
  logic [15:0]      r_len;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_word;
  logic [TO_W-1:0]  r_to_cnt;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic             w_to_active;
  logic             w_timeout;
  logic [15:0]      w_len_full;
  logic             w_last_word;

  // ---------------- RX front end ----------------
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      // NOTE: synchronizer flops reset to the idle-high line level so reset release is not seen as a start edge.
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_rx_valid <= 1'b0;
      r_rx_byte  <= '0;
      frame_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here sees the pre-edge value of the others.
      r_rx_meta  <= uart_txd_in;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_valid <= 1'b0;
      if (w_timeout) begin
        r_rx_state <= RX_IDLE;
      end else begin
        case (r_rx_state)
          RX_IDLE: begin
            if (r_rx_prev && !r_rx_sync) begin
              r_bit_cnt  <= '0;
              r_rx_state <= RX_START;
            end
          end
          RX_START: begin
            if (r_bit_cnt == HALF_LAST) begin
              r_bit_cnt  <= '0;
              r_bit_idx  <= '0;
              r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_shift   <= {r_rx_sync, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 1'b1;
              if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          RX_STOP: begin
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt  <= '0;
              r_rx_state <= RX_IDLE;
              if (r_rx_sync) begin
                r_rx_valid <= 1'b1;
                r_rx_byte  <= r_shift;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // ---------------- inter-byte timeout ----------------
`ifdef BOOT_CHECKSUM_EN
  assign w_to_active = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
`else
  assign w_to_active = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                       (r_state == S_DATA);
`endif
  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_timeout = w_to_active && !r_rx_valid && (r_to_cnt == TO_LAST);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_to_cnt <= '0;
    end else if (r_rx_valid || !w_to_active) begin
      r_to_cnt <= '0;
    end else if (!w_timeout) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // ---------------- protocol FSM ----------------
  assign w_len_full  = {r_rx_byte, r_len[7:0]};
  assign w_last_word = (17'(words_loaded) + 17'd1) == {1'b0, r_len};

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state      <= S_SYNC;
      r_len        <= '0;
      r_byte_cnt   <= '0;
      r_word       <= '0;
`ifdef BOOT_CHECKSUM_EN
      r_csum       <= '0;
`endif
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_run      <= 1'b0;
      boot_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (w_timeout) begin
        r_state  <= S_ERR;
        boot_err <= 1'b1;
        cpu_run  <= 1'b0;
      end else if (r_rx_valid) begin
        case (r_state)
          S_SYNC: begin
            if (r_rx_byte == SYNC_BYTE) r_state <= S_LEN0;
          end
          S_LEN0: begin
            r_len[7:0] <= r_rx_byte;
            r_state    <= S_LEN1;
          end
          S_LEN1: begin
            r_len[15:8] <= r_rx_byte;
            r_byte_cnt  <= '0;
            if ({1'b0, w_len_full} > MAX_LEN) begin
              r_state  <= S_ERR;
              boot_err <= 1'b1;
            end else if (w_len_full == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
              r_state <= S_CSUM;
`else
              r_state <= S_DONE;
              cpu_run <= 1'b1;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            // Little-endian: earliest byte ends up in the low lane.
            r_word     <= {r_rx_byte, r_word[23:8]};
            r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef BOOT_CHECKSUM_EN
            r_csum     <= r_csum + r_rx_byte;
`endif
            if (r_byte_cnt == 2'd3) begin
              mem_we       <= 1'b1;
              mem_addr     <= words_loaded[ADDR_WIDTH-1:0];
              mem_wdata    <= {r_rx_byte, r_word};
              words_loaded <= words_loaded + 1'b1;
              if (w_last_word) begin
`ifdef BOOT_CHECKSUM_EN
                r_state <= S_CSUM;
`else
                r_state <= S_DONE;
                cpu_run <= 1'b1;
`endif
              end
            end
          end
`ifdef BOOT_CHECKSUM_EN
          S_CSUM: begin
            if (r_rx_byte == r_csum) begin
              r_state <= S_DONE;
              cpu_run <= 1'b1;
            end else begin
              r_state  <= S_ERR;
              boot_err <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed scenarios plus randomized images against a byte-level model.
module tb_uart_boot_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;
  localparam int TO  = 200;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxd = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_run;
  logic          boot_err;
  logic          frame_err;
  logic [AW:0]   words_loaded;

  logic [AW+31:0] wr_q[$];
  logic [AW+31:0] exp_wr_q[$];
  int             wr_base = 0;
  logic           exp_run;
  logic           exp_err;
  int             vectors = 0;
  int             miscompares = 0;

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .uart_txd_in (rxd),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_run     (cpu_run),
    .boot_err    (boot_err),
    .frame_err   (frame_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int n_wr();
    return wr_q.size() - wr_base;
  endfunction

  function automatic logic [AW+31:0] get_wr(input int i);
    if (wr_base + i < wr_q.size()) return wr_q[wr_base + i];
    return 'x;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_bit(input logic v);
    rxd = v;
    wait_clks(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_bit);
    rxd = 1'b1;
    wait_clks(2 * CPB);
  endtask

  task automatic send_bytes(input byte_q_t q);
    foreach (q[i]) send_byte(q[i], 1'b1);
    wait_clks(4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    wr_base = wr_q.size();
    rst_n = 1'b1;
    wait_clks(3);
  endtask

  // Byte-level reference: first 0xA5 opens the header, then a 16-bit LE length, then LE words.
  task automatic model(input byte_q_t b);
    int k;
    int p;
    int len;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum;
    sum = '0;
`endif
    exp_wr_q.delete();
    exp_run = 1'b0;
    exp_err = 1'b0;
    k = -1;
    foreach (b[i]) if (k < 0 && b[i] == 8'hA5) k = i;
    if (k < 0 || k + 2 >= b.size()) return;
    len = int'(b[k+1]) + 256 * int'(b[k+2]);
    if (len > (1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    p = k + 3;
    for (int w = 0; w < len; w++) begin
      if (p + 3 >= b.size()) return;
      exp_wr_q.push_back({AW'(w), b[p+3], b[p+2], b[p+1], b[p]});
`ifdef BOOT_CHECKSUM_EN
      sum = sum + b[p] + b[p+1] + b[p+2] + b[p+3];
`endif
      p += 4;
    end
`ifdef BOOT_CHECKSUM_EN
    if (p < b.size()) begin
      if (b[p] == sum) exp_run = 1'b1;
      else exp_err = 1'b1;
    end
`else
    exp_run = 1'b1;
`endif
  endtask

  task automatic check_image(input string tag);
    check({tag, ".n_writes"}, n_wr(), exp_wr_q.size());
    foreach (exp_wr_q[i]) check($sformatf("%s.write%0d", tag, i), get_wr(i), exp_wr_q[i]);
    check({tag, ".words_loaded"}, words_loaded, exp_wr_q.size());
    check({tag, ".cpu_run"}, cpu_run, exp_run);
    check({tag, ".boot_err"}, boot_err, exp_err);
    check({tag, ".frame_err"}, frame_err, 0);
  endtask

  initial begin
    byte_q_t img;
    byte_q_t q;
    int len;
    int junk;
    logic [7:0] r;
    logic [7:0] csum;

    img = '{8'h00, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    img.push_back(8'h82);
`endif

    // Reset state, sampled while reset is asserted.
    rst_n = 1'b0;
    wait_clks(2);
    check("reset.outputs", {mem_we, mem_addr, mem_wdata, cpu_run, boot_err, frame_err, words_loaded}, 0);
    rst_n = 1'b1;
    wait_clks(3);

    // Nominal two-word image.
    send_bytes(img);
    model(img);
    check_image("basic");
    check("basic.addr0", get_wr(0), {4'd0, 32'h0000_0013});
    check("basic.addr1", get_wr(1), {4'd1, 32'h0000_006F});
    check("basic.last_addr_held", mem_addr, 1);
    check("basic.last_data_held", mem_wdata, 32'h6F);
    send_bytes('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
    check("done.ignores_bytes", n_wr(), 2);
    check("done.cpu_run_held", cpu_run, 1);

    // Oversized length.
    do_reset();
    q = '{8'hA5, 8'h11, 8'h00};
    send_bytes(q);
    model(q);
    check_image("too_long");
    check("too_long.boot_err", boot_err, 1);

    // Framing error mid-image, then the line idles into a timeout.
    do_reset();
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13});
    send_byte(8'h00, 1'b0);
    check("frame.frame_err", frame_err, 1);
    check("frame.boot_err_before_timeout", boot_err, 0);
    wait_clks(TO);
    check("frame.boot_err_after_timeout", boot_err, 1);
    check("frame.no_writes", n_wr(), 0);
    check("frame.cpu_run", cpu_run, 0);

`ifdef BOOT_CHECKSUM_EN
    // Bad checksum: data is written but the cpu is not released.
    do_reset();
    q = img;
    q[q.size()-1] = 8'h83;
    send_bytes(q);
    model(q);
    check_image("bad_csum");
    check("bad_csum.boot_err", boot_err, 1);
`endif

    // One-clock glitch on the idle line, then a valid image.
    do_reset();
    rxd = 1'b0;
    wait_clks(1);
    rxd = 1'b1;
    wait_clks(3 * CPB);
    check("glitch.frame_err", frame_err, 0);
    send_bytes(img);
    model(img);
    check_image("glitch");

    // Asynchronous reset mid-image, then a full resend.
    do_reset();
    send_bytes('{8'hA5, 8'h03, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    send_byte(8'h55, 1'b0);
    send_bytes('{8'h01, 8'h02});
    check("midreset.words_before", words_loaded, 1);
    check("midreset.data_before", mem_wdata, 32'hDEAD_BEEF);
    check("midreset.frame_before", frame_err, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset.outputs", {mem_we, mem_addr, mem_wdata, cpu_run, boot_err, frame_err, words_loaded}, 0);
    @(posedge clk);
    #1;
    wr_base = wr_q.size();
    rst_n = 1'b1;
    wait_clks(3);
    send_bytes(img);
    model(img);
    check_image("resend");

    // Randomized images, including junk before the sync byte and oversize lengths.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      q.delete();
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        r = 8'($urandom_range(0, 255));
        if (r == 8'hA5) r = 8'h5A;
        q.push_back(r);
      end
      len = $urandom_range(0, 18);
      q.push_back(8'hA5);
      q.push_back(8'(len));
      q.push_back(8'h00);
      csum = '0;
      if (len <= (1 << AW)) begin
        for (int j = 0; j < 4 * len; j++) begin
          r = 8'($urandom_range(0, 255));
          csum = csum + r;
          q.push_back(r);
        end
`ifdef BOOT_CHECKSUM_EN
        if ($urandom_range(0, 3) == 0) csum = csum ^ 8'h01;
        q.push_back(csum);
`endif
      end
      send_bytes(q);
      model(q);
      check_image($sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
